// File: rtl/rice_residual_decoder.sv
// Bit-serial FLAC Rice residual decoder for one partition.
// Decodes Rice codes and escape-coded raw residuals into signed samples.
module rice_residual_decoder #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned MAX_Q  = 4095
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iStart,
  input  logic [3:0]        iRiceParam,
  input  logic [CNT_W-1:0]  iCount,
  input  logic              iBit,
  input  logic              iBitValid,
  output logic              oBitReady,
  output logic [DATA_W-1:0] oResidual,
  output logic              oValid,
  output logic              oBusy,
  output logic              oDone,
  output logic              oError
);

  localparam int unsigned Q_W = $clog2(MAX_Q + 1);

  typedef enum logic [2:0] {IDLE, UNARY, REM, ESC_W, RAW, ZERO, DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_k;
  logic [CNT_W-1:0]    r_cnt;
  logic [Q_W-1:0]      r_q;
  logic [30:0]         r_sh;
  logic [4:0]          r_nbits;
  logic [4:0]          r_width;
  logic [DATA_W-1:0]   r_residual;
  logic                r_valid;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic                r_bit_ready;

  logic                w_xfer;
  logic [31:0]         w_shift;
  logic [31:0]         w_q_inc;
  logic [31:0]         w_u;
  logic [31:0]         w_sext;
  logic [4:0]          w_msb;
  logic [4:0]          w_k_last;
  logic                w_emit;
  logic                w_use_raw;
  logic                w_overflow;
  logic                w_esc_end;
  logic                w_done_c;
  logic                w_ready_nxt;
  logic [DATA_W-1:0]   w_res;

  // State register
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next-state, code assembly and residual value
  always_comb begin
    w_next      = r_state;
    w_emit      = 1'b0;
    w_use_raw   = 1'b0;
    w_overflow  = 1'b0;
    w_esc_end   = 1'b0;
    w_u         = 32'd0;
    w_xfer      = r_bit_ready & iBitValid;
    w_shift     = {r_sh, iBit};
    w_q_inc     = 32'(r_q) + 32'd1;
    w_msb       = r_width - 5'd1;
    w_k_last    = 5'(r_k) - 5'd1;
    w_sext      = w_shift[w_msb] ? (w_shift | (32'hFFFF_FFFF << r_width)) : w_shift;

    case (r_state)
      IDLE: begin
        if (iStart) begin
          if (iCount == CNT_W'(0))     w_next = DONE;
          else if (iRiceParam == 4'hF) w_next = ESC_W;
          else                         w_next = UNARY;
        end
      end
      UNARY: begin
        if (w_xfer) begin
          if (!iBit) begin
            if (w_q_inc > 32'(MAX_Q)) begin
              w_overflow = 1'b1;
              w_next     = DONE;
            end
          end else if (r_k != 4'd0) begin
            w_next = REM;
          end else begin
            w_emit = 1'b1;
            w_u    = 32'(r_q);
          end
        end
      end
      REM: begin
        if (w_xfer && (r_nbits == w_k_last)) begin
          w_emit = 1'b1;
          w_u    = (32'(r_q) << r_k) | w_shift;
        end
      end
      ESC_W: begin
        if (w_xfer && (r_nbits == 5'd4)) begin
          w_esc_end = 1'b1;
          w_next    = (w_shift[4:0] == 5'd0) ? ZERO : RAW;
        end
      end
      RAW: begin
        if (w_xfer && (r_nbits == w_msb)) begin
          w_emit    = 1'b1;
          w_use_raw = 1'b1;
        end
      end
      ZERO:    w_emit = 1'b1;
      DONE:    w_next = r_done ? IDLE : DONE;
      default: w_next = IDLE;
    endcase

    // The last residual of the partition always lands in DONE
    if (w_emit) begin
      if (r_cnt == CNT_W'(1))  w_next = DONE;
      else if (r_state == RAW) w_next = RAW;
      else if (r_state == ZERO) w_next = ZERO;
      else                     w_next = UNARY;
    end

    // Zigzag: even u -> u/2, odd u -> -(u/2)-1 == ~(u/2)
    if (w_use_raw)  w_res = DATA_W'(w_sext);
    else if (w_u[0]) w_res = DATA_W'(~(w_u >> 1));
    else             w_res = DATA_W'(w_u >> 1);

    // oDone pulses on DONE entry, or one cycle later when DONE follows a residual
    w_done_c    = ((w_next == DONE) && (r_state != DONE) && !w_emit) ||
                  ((r_state == DONE) && !r_done);
    w_ready_nxt = (w_next == UNARY) || (w_next == REM) ||
                  (w_next == ESC_W) || (w_next == RAW);
  end

  // Datapath and registered outputs
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_k         <= 4'd0;
      r_cnt       <= '0;
      r_q         <= '0;
      r_sh        <= '0;
      r_nbits     <= 5'd0;
      r_width     <= 5'd0;
      r_residual  <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_bit_ready <= 1'b0;
    end else begin
      r_valid     <= w_emit;
      r_done      <= w_done_c;
      r_busy      <= (w_next != IDLE);
      r_bit_ready <= w_ready_nxt;
      if (w_emit)     r_residual <= w_res;
      if (w_overflow) r_error    <= 1'b1;
      if ((r_state == IDLE) && iStart) begin
        r_k     <= iRiceParam;
        r_cnt   <= iCount;
        r_error <= 1'b0;
        r_q     <= '0;
        r_sh    <= '0;
        r_nbits <= 5'd0;
      end else begin
        if (w_emit) r_cnt <= r_cnt - CNT_W'(1);
        if (w_emit)
          r_q <= '0;
        else if (w_xfer && (r_state == UNARY) && !iBit)
          r_q <= Q_W'(w_q_inc);
        if (w_emit || w_esc_end) begin
          r_sh    <= '0;
          r_nbits <= 5'd0;
        end else if (w_xfer && (r_state != UNARY)) begin
          r_sh    <= w_shift[30:0];
          r_nbits <= r_nbits + 5'd1;
        end
        if (w_esc_end) r_width <= w_shift[4:0];
      end
    end
  end

  assign oBitReady = r_bit_ready;
  assign oResidual = r_residual;
  assign oValid    = r_valid;
  assign oBusy     = r_busy;
  assign oDone     = r_done;
  assign oError    = r_error;

endmodule

// File: doc/rice_residual_decoder.md
Name: rice_residual_decoder

Overview:
- Bit-serial FLAC Rice residual decoder for one partition; sits directly upstream of the fixed-predictor stage.
- Consumes the entropy-coded bitstream one bit per handshake and decodes Rice codes and escape-coded raw residuals.
- Emits one signed residual per valid pulse; oValid drives the predictor's iEnable and oResidual drives its iSample.

Parameters:
- DATA_W, 16, width of output residual (two's complement)
- CNT_W, 16, width of partition sample count
- MAX_Q, 4095, largest legal unary quotient; larger sets error

Ports:
- iClk  input  1  clock, rising edge
- iRst_n  input  1  asynchronous active-low reset
- iStart  input  1  single-cycle pulse; latch iRiceParam/iCount, begin partition
- iRiceParam  input  4  Rice parameter k (0..14); 15 = escape
- iCount  input  CNT_W  residuals in partition
- iBit  input  1  next stream bit, MSB-first
- iBitValid  input  1  iBit valid this cycle
- oBitReady  output  1  decoder consumes iBit this cycle when iBitValid=1
- oResidual  output  DATA_W  decoded signed residual
- oValid  output  1  one-cycle pulse, oResidual valid
- oBusy  output  1  partition in progress
- oDone  output  1  one-cycle pulse after last residual of partition
- oError  output  1  sticky quotient overflow; cleared by iStart or reset

Behaviour:
- Reset (async, iRst_n=0): state IDLE; oResidual=0, oValid=0, oBusy=0, oDone=0, oError=0, oBitReady=0; counters cleared. A reset mid-partition abandons the partition; no further outputs until next iStart.
- Bit transfer occurs only when oBitReady && iBitValid. Stall cycles (iBitValid=0) hold all state.
- States:
  - IDLE: oBitReady=0. On iStart: latch k and count, clear oError. If count=0 -> DONE. Else if k=15 -> ESC_W, otherwise UNARY.
  - UNARY: each 0 bit increments q. A 1 bit ends the quotient: go to REM if k>0; if k=0, emit.
  - REM: shift in k bits, MSB-first. Emit after the k-th bit.
  - ESC_W: shift in 5 bits as width n. If n=0 -> ZERO. Else -> RAW.
  - RAW: shift in n bits as an n-bit two's complement value, sign-extended to DATA_W. Emit after the n-th bit. Remain in RAW until count is exhausted (n is held for the whole partition).
  - ZERO: no bits consumed (oBitReady=0). Emit 0 once per cycle until count is exhausted.
  - DONE: oDone=1 for one cycle, then IDLE.
- Rice value:
  - u = (q<<k)|r, computed in 32-bit unsigned.
  - Zigzag: u even -> u>>1; u odd -> -(u>>1)-1.
  - Result is truncated to DATA_W (wraps, no saturation).
- Latency: oValid asserts on the cycle after the final bit of the code is consumed.
  - oResidual is registered and holds its value between pulses.
  - Back-to-back codes can be consumed without bubbles.
- Count: decremented on each emit. On the emit of the last residual, the next state is DONE, so oDone asserts the cycle after the last oValid.
- Overflow: if q exceeds MAX_Q during UNARY, set oError and go to DONE; the remaining partition is discarded.
- oBusy=1 in every state except IDLE.
- iStart while oBusy=1 is ignored.
- oBitReady=1 in UNARY, REM, ESC_W and RAW only.
- No backpressure on outputs: the consumer must accept every oValid pulse.

Test Plan:
- k=2, count=3, bits 0 1 1 0 1 1 1 1 0 0 (all valid) -> residuals 3, -2, 0.
  - oValid on the cycles after the 4th, 7th and 10th bit.
  - oDone one cycle after the last residual.
- k=0, count=2, bits 0 1 1 -> -1, 0. Repeat with iBitValid deasserted every other cycle -> same values, pulses delayed accordingly.
- Escape: param 15, count=2, bits 0 0 1 0 0 | 1 0 1 1 | 0 1 1 1 -> -5, 7.
- Escape with width 0 (bits 0 0 0 0 0), count=3:
  - Three consecutive oValid pulses with residual 0.
  - oBitReady low throughout the ZERO state.
  - oDone follows.
- Overflow: MAX_Q=4 with 5 leading zeros -> oError=1, oDone pulse, IDLE. The next iStart clears oError.
- Reset mid-UNARY: assert iRst_n=0 asynchronously between clock edges -> all outputs 0 immediately, no oValid after release. A new partition (count=0) then gives oDone one cycle after iStart, with no bits consumed.
